lcd_init_seq: RTL and testbench
===============================

# lcd_init_seq

Power-on initialisation sequencer for the LCD panel. It pulses the panel hardware reset, then walks a command ROM of command writes, parameter writes and millisecond delays. It presents one write at a time on the init-side port of the LCD arbitration mux and steps only on the interface's write-acknowledge. When the table ends it raises a sticky `init_finish`, which hands the panel over to the CPU drawing path.

## Interface
Parameters:
- `ROM_DEPTH`, 64: number of init table entries; index width is `$clog2(ROM_DEPTH)`.
- `RST_LOW_CYC`, 10000: pclk cycles that `lcd_rst_n_o` is held low.
- `RST_WAIT_CYC`, 120000: pclk cycles to wait after `lcd_rst_n_o` rises, before the first write.
- `MS_CYC`, 50000: pclk cycles per delay millisecond.

Ports:
- `pclk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `restart` in 1: single-cycle pulse that re-runs the whole sequence. Honoured only in DONE.
- `init_write_ok` in 1: interface acknowledge that the current write has completed.
- `init_data` out 16: command or parameter value.
- `init_we` out 1: write request, held until acknowledged.
- `init_wr` out 1: always 1 during a request (write); 0 otherwise.
- `init_rs` out 1: 0 = command, 1 = parameter data.
- `init_work` out 1: the sequence is in progress.
- `init_finish` out 1: initialisation complete (sticky).
- `lcd_rst_n_o` out 1: panel hardware reset, active-low.

## Operation
- ROM entry layout: `{kind[1:0], val[15:0]}`.
  - `kind` values: CMD=0, DATA=1, DLY=2, END=3.
  - For DLY entries, `val` is the delay in milliseconds.
- States and transitions:
  - **IDLE**: entered only while `rst` is high. The cycle after `rst` falls, go to HW_RST.
  - **HW_RST**: `lcd_rst_n_o`=0. Stay RST_LOW_CYC cycles, then go to HW_WAIT.
  - **HW_WAIT**: `lcd_rst_n_o`=1. Stay RST_WAIT_CYC cycles, then set idx=0 and go to FETCH.
  - **FETCH**: one cycle. Registered ROM read of `rom[idx]`. Then go to DECODE.
  - **DECODE**: branch on `kind`:
    - CMD → WRITE with `init_rs`=0.
    - DATA → WRITE with `init_rs`=1.
    - DLY with `val`≠0 → DELAY.
    - DLY with `val`=0 → idx++, then FETCH.
    - END → DONE.
  - **WRITE**: `init_we`=1, `init_wr`=1, `init_data`/`init_rs` stable.
    - On the cycle `init_write_ok`=1: idx++, go to FETCH, and `init_we` drops the next cycle.
  - **DELAY**: nested counters, cycle count 0..MS_CYC-1 and ms count 0..val-1. When both are terminal: idx++, go to FETCH.
  - **DONE**: `init_finish`=1. On `restart`, go to HW_RST and clear `init_finish`.
- Table end: if idx increments past ROM_DEPTH-1 without an END entry, go to DONE (implicit END). No wrap-around.
- `init_write_ok` outside WRITE is ignored. No counter or state change.
- `restart` outside DONE is ignored.
- `rst` in any state, mid-write or mid-delay: the next state is IDLE and every output returns to its reset value. There is no partial resume.
- `init_work` = 1 in HW_RST, HW_WAIT, FETCH, DECODE, WRITE and DELAY; 0 in IDLE and DONE.
- Counters: widths are `$clog2` of the largest cycle parameter, plus 16 bits for ms. No overflow is possible by construction.

## Timing
- Reset values:
  - `init_data`=0, `init_we`=0, `init_wr`=0, `init_rs`=0, `init_work`=0, `init_finish`=0, `lcd_rst_n_o`=0.
- All outputs are registered.
- `init_work` rises 1 cycle after `rst` falls.
- First write request: `init_we` rises at RST_LOW_CYC + RST_WAIT_CYC + 3 cycles after `rst` falls.
- Per write: FETCH + DECODE add 2 cycles.
  - `init_we` rises in the cycle after DECODE.
  - Minimum spacing between writes is 3 cycles when `init_write_ok` is asserted on the first WRITE cycle.
- Per delay: val·MS_CYC cycles in DELAY, plus 2 cycles of FETCH/DECODE overhead.
- `init_finish` rises 2 cycles after the last acknowledged write, through FETCH of the END entry and then DECODE. `init_work` falls in the same cycle.

## Structure
- `lcd_pkg` holds:
  - the `init_kind_e` enum;
  - the `init_entry_t` packed struct;
  - the `lcd_init_state_e` enum;
  - the panel command constants (e.g. SLPOUT=16'h0011, DISPON=16'h0029, MADCTL=16'h0036).
- Sub-module `lcd_init_rom`: synchronous-read ROM, address → `init_entry_t`, with the table initialised from a package constant. This lets benches substitute a short table.

## Test plan
All scenarios use RST_LOW_CYC=4, RST_WAIT_CYC=8, MS_CYC=10.
1. Release `rst` with table {CMD 0x11, END} and acknowledge after 2 cycles → `lcd_rst_n_o` low for 4 cycles, then `init_we` at cycle 15 with `init_data`=0x0011 and `init_rs`=0. `init_we` stays high until the ack. `init_finish` rises 2 cycles after the ack and stays high.
2. Table {CMD 0x36, DATA 0x0048, END}, ack delayed by 0 cycles and then by 7 → data/rs stable for the whole request. The second write shows `init_rs`=1 and `init_data`=0x0048.
3. Table {DLY 3, CMD 0x29, END} → DELAY lasts exactly 30 cycles. Table {DLY 0, CMD 0x29, END} → the command is issued with no DELAY cycles.
4. Spurious `init_write_ok` during HW_WAIT and DELAY → no idx change and no early exit.
5. Assert `rst` mid-WRITE and mid-DELAY → all outputs return to reset values the next cycle. The sequence restarts from HW_RST after release.
6. Table with no END (ROM_DEPTH=2, both CMD) → DONE after the 2nd ack. `restart` in DONE reruns the sequence and clears `init_finish` for the whole duration.

Source files
------------

// File: rtl/lcd_init_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types, panel command codes and default init table for
//               the LCD power-on initialisation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [1:0] {
        KIND_CMD  = 2'd0,
        KIND_DATA = 2'd1,
        KIND_DLY  = 2'd2,
        KIND_END  = 2'd3
    } init_kind_e;

    typedef struct packed {
        init_kind_e  kind;
        logic [15:0] val;
    } init_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HW_RST  = 3'd1,
        ST_HW_WAIT = 3'd2,
        ST_FETCH   = 3'd3,
        ST_DECODE  = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DELAY   = 3'd6,
        ST_DONE    = 3'd7
    } lcd_init_state_e;

    // Table storage is fixed at the maximum depth; shallower ROMs use the low entries.
    localparam int c_rom_max = 64;
    localparam int c_rom_aw  = $clog2(c_rom_max);

    typedef init_entry_t [c_rom_max-1:0] init_table_t;

    localparam logic [15:0] c_cmd_slpout = 16'h0011;
    localparam logic [15:0] c_cmd_invon  = 16'h0021;
    localparam logic [15:0] c_cmd_dispon = 16'h0029;
    localparam logic [15:0] c_cmd_caset  = 16'h002A;
    localparam logic [15:0] c_cmd_raset  = 16'h002B;
    localparam logic [15:0] c_cmd_ramwr  = 16'h002C;
    localparam logic [15:0] c_cmd_madctl = 16'h0036;
    localparam logic [15:0] c_cmd_colmod = 16'h003A;

    function automatic init_entry_t init_ent(input init_kind_e k, input logic [15:0] v);
        init_entry_t e;
        e.kind = k;
        e.val  = v;
        return e;
    endfunction

    function automatic init_table_t default_init_table();
        init_table_t t;
        for (int i = 0; i < c_rom_max; i++) begin
            t[i] = init_ent(KIND_END, 16'h0000);
        end
        t[0]  = init_ent(KIND_CMD,  c_cmd_slpout);
        t[1]  = init_ent(KIND_DLY,  16'd120);
        t[2]  = init_ent(KIND_CMD,  c_cmd_colmod);
        t[3]  = init_ent(KIND_DATA, 16'h0055);
        t[4]  = init_ent(KIND_CMD,  c_cmd_madctl);
        t[5]  = init_ent(KIND_DATA, 16'h0048);
        t[6]  = init_ent(KIND_CMD,  c_cmd_caset);
        t[7]  = init_ent(KIND_DATA, 16'h0000);
        t[8]  = init_ent(KIND_DATA, 16'h0000);
        t[9]  = init_ent(KIND_DATA, 16'h0000);
        t[10] = init_ent(KIND_DATA, 16'h00EF);
        t[11] = init_ent(KIND_CMD,  c_cmd_raset);
        t[12] = init_ent(KIND_DATA, 16'h0000);
        t[13] = init_ent(KIND_DATA, 16'h0000);
        t[14] = init_ent(KIND_DATA, 16'h0001);
        t[15] = init_ent(KIND_DATA, 16'h003F);
        t[16] = init_ent(KIND_CMD,  c_cmd_invon);
        t[17] = init_ent(KIND_CMD,  c_cmd_dispon);
        t[18] = init_ent(KIND_DLY,  16'd20);
        t[19] = init_ent(KIND_CMD,  c_cmd_ramwr);
        return t;
    endfunction

    localparam init_table_t c_init_table = default_init_table();

endpackage
`default_nettype wire

// File: rtl/lcd_init_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_seq_if
// Description : Init-side port of the LCD arbitration mux plus panel reset.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_init_seq_if;

    logic        restart;
    logic        init_write_ok;
    logic [15:0] init_data;
    logic        init_we;
    logic        init_wr;
    logic        init_rs;
    logic        init_work;
    logic        init_finish;
    logic        lcd_rst_n_o;

    modport master (
        input  restart,
        input  init_write_ok,
        output init_data,
        output init_we,
        output init_wr,
        output init_rs,
        output init_work,
        output init_finish,
        output lcd_rst_n_o
    );

    modport slave (
        output restart,
        output init_write_ok,
        input  init_data,
        input  init_we,
        input  init_wr,
        input  init_rs,
        input  init_work,
        input  init_finish,
        input  lcd_rst_n_o
    );

endinterface
`default_nettype wire

// File: rtl/lcd_init_seq_rom.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_rom
// Description : Synchronous-read init command ROM, contents set by parameter.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int          ADDR_W   = 6,
    parameter init_table_t ROM_INIT = c_init_table
) (
    input  wire logic              pclk,
    input  wire logic [ADDR_W-1:0] i_addr,
    output init_entry_t            o_entry
);

    logic [c_rom_aw-1:0] w_addr_ext;

    assign w_addr_ext = c_rom_aw'(i_addr);

    always_ff @(posedge pclk) begin
        o_entry <= ROM_INIT[w_addr_ext];
    end

endmodule
`default_nettype wire

// File: rtl/lcd_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_seq
// Description : LCD power-on sequencer: hardware reset pulse, then command ROM
//               walk of writes and ms delays, ending in a sticky init_finish.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter int          ROM_DEPTH    = 64,
    parameter int          RST_LOW_CYC  = 10000,
    parameter int          RST_WAIT_CYC = 120000,
    parameter int          MS_CYC       = 50000,
    parameter init_table_t ROM_INIT     = c_init_table
) (
    input  wire logic      pclk,
    input  wire logic      rst,
    lcd_init_seq_if.master bus
);

    localparam int c_aw      = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int c_cyc_max = (RST_LOW_CYC > RST_WAIT_CYC)
                             ? ((RST_LOW_CYC > MS_CYC) ? RST_LOW_CYC : MS_CYC)
                             : ((RST_WAIT_CYC > MS_CYC) ? RST_WAIT_CYC : MS_CYC);
    localparam int c_cw      = (c_cyc_max > 1) ? $clog2(c_cyc_max) : 1;

    localparam logic [c_cw-1:0] c_low_last  = c_cw'(RST_LOW_CYC - 1);
    localparam logic [c_cw-1:0] c_wait_last = c_cw'(RST_WAIT_CYC - 1);
    localparam logic [c_cw-1:0] c_ms_last   = c_cw'(MS_CYC - 1);
    localparam logic [c_aw-1:0] c_idx_last  = c_aw'(ROM_DEPTH - 1);

    lcd_init_state_e r_state;
    lcd_init_state_e w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_nxt;
    logic [15:0]     r_ms;
    logic [15:0]     w_ms_nxt;
    logic [c_aw-1:0] r_idx;
    logic [c_aw-1:0] w_idx_nxt;
    logic [15:0]     r_data;
    logic [15:0]     w_data_nxt;
    logic            r_rs;
    logic            w_rs_nxt;
    logic            w_step;
    logic            r_we;
    logic            r_work;
    logic            r_finish;
    logic            r_rst_n;
    init_entry_t     w_entry;

    lcd_init_rom #(
        .ADDR_W   (c_aw),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .pclk    (pclk),
        .i_addr  (r_idx),
        .o_entry (w_entry)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ms_nxt    = r_ms;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_rs_nxt    = r_rs;
        w_step      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_HW_RST;
                w_cnt_nxt   = '0;
            end
            ST_HW_RST: begin
                if (r_cnt == c_low_last) begin
                    w_state_nxt = ST_HW_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cw'(1);
                end
            end
            ST_HW_WAIT: begin
                if (r_cnt == c_wait_last) begin
                    w_state_nxt = ST_FETCH;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cw'(1);
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_entry.kind)
                    KIND_CMD, KIND_DATA: begin
                        w_state_nxt = ST_WRITE;
                        w_data_nxt  = w_entry.val;
                        w_rs_nxt    = (w_entry.kind == KIND_DATA);
                    end
                    KIND_DLY: begin
                        if (w_entry.val != 16'd0) begin
                            w_state_nxt = ST_DELAY;
                            w_cnt_nxt   = '0;
                            w_ms_nxt    = '0;
                        end else begin
                            w_step = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_DONE;
                    end
                endcase
            end
            ST_WRITE: begin
                w_step = bus.init_write_ok;
            end
            ST_DELAY: begin
                // The ROM address is frozen here, so w_entry.val still holds the delay.
                if (r_cnt == c_ms_last) begin
                    w_cnt_nxt = '0;
                    if (r_ms == w_entry.val - 16'd1) begin
                        w_step = 1'b1;
                    end else begin
                        w_ms_nxt = r_ms + 16'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cw'(1);
                end
            end
            ST_DONE: begin
                if (bus.restart) begin
                    w_state_nxt = ST_HW_RST;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Running off the last entry behaves as an implicit END.
        if (w_step) begin
            if (r_idx == c_idx_last) begin
                w_state_nxt = ST_DONE;
            end else begin
                w_idx_nxt   = r_idx + c_aw'(1);
                w_state_nxt = ST_FETCH;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ms     <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_rs     <= 1'b0;
            r_we     <= 1'b0;
            r_work   <= 1'b0;
            r_finish <= 1'b0;
            r_rst_n  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ms     <= w_ms_nxt;
            r_idx    <= w_idx_nxt;
            r_data   <= w_data_nxt;
            r_rs     <= w_rs_nxt;
            r_we     <= (w_state_nxt == ST_WRITE);
            r_work   <= !(w_state_nxt inside {ST_IDLE, ST_DONE});
            r_finish <= (w_state_nxt == ST_DONE);
            r_rst_n  <= !(w_state_nxt inside {ST_IDLE, ST_HW_RST});
        end
    end

    assign bus.init_data   = r_data;
    assign bus.init_we     = r_we;
    assign bus.init_wr     = r_we;
    assign bus.init_rs     = r_rs;
    assign bus.init_work   = r_work;
    assign bus.init_finish = r_finish;
    assign bus.lcd_rst_n_o = r_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_lcd_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_init_seq
// Description : Scoreboard bench for lcd_init_seq over five short init tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_init_seq;
    import lcd_pkg::*;

    localparam int c_n = 5;
    localparam int c_b_we = 5, c_b_wr = 4, c_b_rs = 3, c_b_work = 2, c_b_fin = 1, c_b_rstn = 0;

    typedef struct packed { logic rs; logic [15:0] data; } wr_t;

    function automatic init_table_t mk_table(input init_entry_t e0, input init_entry_t e1,
                                             input init_entry_t e2);
        init_table_t t;
        for (int i = 0; i < c_rom_max; i++) t[i] = init_ent(KIND_END, 16'h0000);
        t[0] = e0;
        t[1] = e1;
        t[2] = e2;
        return t;
    endfunction

    localparam init_table_t c_t0 = mk_table(init_ent(KIND_CMD, 16'h0011),
        init_ent(KIND_END, 16'h0000), init_ent(KIND_END, 16'h0000));
    localparam init_table_t c_t1 = mk_table(init_ent(KIND_CMD, 16'h0036),
        init_ent(KIND_DATA, 16'h0048), init_ent(KIND_END, 16'h0000));
    localparam init_table_t c_t2 = mk_table(init_ent(KIND_DLY, 16'd3),
        init_ent(KIND_CMD, 16'h0029), init_ent(KIND_END, 16'h0000));
    localparam init_table_t c_t3 = mk_table(init_ent(KIND_DLY, 16'd0),
        init_ent(KIND_CMD, 16'h0029), init_ent(KIND_END, 16'h0000));
    localparam init_table_t c_t4 = mk_table(init_ent(KIND_CMD, 16'h0011),
        init_ent(KIND_CMD, 16'h0029), init_ent(KIND_END, 16'h0000));

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        ack     [c_n];
    logic        restart [c_n];
    logic [21:0] obs     [c_n];
    wr_t         exp_q   [$];
    int          checks = 0;
    int          errors = 0;

    always #5 pclk = ~pclk;

    lcd_init_seq_if bus0 ();
    lcd_init_seq_if bus1 ();
    lcd_init_seq_if bus2 ();
    lcd_init_seq_if bus3 ();
    lcd_init_seq_if bus4 ();

    lcd_init_seq #(.ROM_DEPTH(4), .RST_LOW_CYC(4), .RST_WAIT_CYC(8), .MS_CYC(10), .ROM_INIT(c_t0))
        u_dut0 (.pclk(pclk), .rst(rst), .bus(bus0));
    lcd_init_seq #(.ROM_DEPTH(4), .RST_LOW_CYC(4), .RST_WAIT_CYC(8), .MS_CYC(10), .ROM_INIT(c_t1))
        u_dut1 (.pclk(pclk), .rst(rst), .bus(bus1));
    lcd_init_seq #(.ROM_DEPTH(4), .RST_LOW_CYC(4), .RST_WAIT_CYC(8), .MS_CYC(10), .ROM_INIT(c_t2))
        u_dut2 (.pclk(pclk), .rst(rst), .bus(bus2));
    lcd_init_seq #(.ROM_DEPTH(4), .RST_LOW_CYC(4), .RST_WAIT_CYC(8), .MS_CYC(10), .ROM_INIT(c_t3))
        u_dut3 (.pclk(pclk), .rst(rst), .bus(bus3));
    lcd_init_seq #(.ROM_DEPTH(2), .RST_LOW_CYC(4), .RST_WAIT_CYC(8), .MS_CYC(10), .ROM_INIT(c_t4))
        u_dut4 (.pclk(pclk), .rst(rst), .bus(bus4));

    assign bus0.init_write_ok = ack[0];
    assign bus0.restart       = restart[0];
    assign obs[0] = {bus0.init_data, bus0.init_we, bus0.init_wr, bus0.init_rs,
                     bus0.init_work, bus0.init_finish, bus0.lcd_rst_n_o};
    assign bus1.init_write_ok = ack[1];
    assign bus1.restart       = restart[1];
    assign obs[1] = {bus1.init_data, bus1.init_we, bus1.init_wr, bus1.init_rs,
                     bus1.init_work, bus1.init_finish, bus1.lcd_rst_n_o};
    assign bus2.init_write_ok = ack[2];
    assign bus2.restart       = restart[2];
    assign obs[2] = {bus2.init_data, bus2.init_we, bus2.init_wr, bus2.init_rs,
                     bus2.init_work, bus2.init_finish, bus2.lcd_rst_n_o};
    assign bus3.init_write_ok = ack[3];
    assign bus3.restart       = restart[3];
    assign obs[3] = {bus3.init_data, bus3.init_we, bus3.init_wr, bus3.init_rs,
                     bus3.init_work, bus3.init_finish, bus3.lcd_rst_n_o};
    assign bus4.init_write_ok = ack[4];
    assign bus4.restart       = restart[4];
    assign obs[4] = {bus4.init_data, bus4.init_we, bus4.init_wr, bus4.init_rs,
                     bus4.init_work, bus4.init_finish, bus4.lcd_rst_n_o};

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Leaves rst low just after an edge, so the next edge is cycle 1 after release.
    task automatic do_release();
        rst = 1'b1;
        for (int i = 0; i < c_n; i++) begin
            ack[i]     = 1'b0;
            restart[i] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard consumer: waits for a request, checks it against the queue head,
    // holds it for 'hold' cycles, acknowledges, and checks the request drops.
    task automatic serve_write(input int n, input int hold, output int waited);
        wr_t e;
        waited = 0;
        while (obs[n][c_b_we] !== 1'b1 && waited < 400) begin
            tick();
            waited++;
        end
        checks++;
        if (obs[n][c_b_we] !== 1'b1) begin
            $display("FAIL wait_we dut%0d: init_we=%b, required 1 within 400 cycles", n, obs[n][c_b_we]);
            errors++;
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write dut%0d: data=%h with empty scoreboard", n, obs[n][21:6]);
            errors++;
            return;
        end
        e = exp_q.pop_front();
        if ({obs[n][c_b_wr], obs[n][c_b_rs], obs[n][21:6]} !== {1'b1, e}) begin
            $display("FAIL write_value dut%0d: wr/rs/data=%b/%b/%h, required 1/%b/%h",
                     n, obs[n][c_b_wr], obs[n][c_b_rs], obs[n][21:6], e.rs, e.data);
            errors++;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if ({obs[n][c_b_we], obs[n][c_b_rs], obs[n][21:6]} !== {1'b1, e}) begin
                $display("FAIL write_hold dut%0d cyc%0d: we/rs/data=%b/%b/%h, required 1/%b/%h",
                         n, i, obs[n][c_b_we], obs[n][c_b_rs], obs[n][21:6], e.rs, e.data);
                errors++;
            end
        end
        ack[n] = 1'b1;
        tick();
        ack[n] = 1'b0;
        checks++;
        if ({obs[n][c_b_we], obs[n][c_b_wr]} !== 2'b00) begin
            $display("FAIL write_drop dut%0d: we/wr=%b/%b, required 0/0", n, obs[n][c_b_we], obs[n][c_b_wr]);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < c_n; i++) begin
            ack[i]     = 1'b0;
            restart[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < c_n; i++) begin
            checks++;
            if (obs[i] !== 22'd0) begin
                $display("FAIL reset_values dut%0d: outputs=%h, required 000000", i, obs[i]);
                errors++;
            end
        end
    endtask

    task automatic test_single_cmd();
        int w;
        do_release();
        exp_q.push_back(wr_t'{1'b0, 16'h0011});
        tick();
        checks++;
        if ({obs[0][c_b_work], obs[0][c_b_rstn]} !== 2'b10) begin
            $display("FAIL work_rise: work/rst_n=%b/%b, required 1/0", obs[0][c_b_work], obs[0][c_b_rstn]);
            errors++;
        end
        repeat (3) tick();
        checks++;
        if (obs[0][c_b_rstn] !== 1'b0) begin
            $display("FAIL rst_low_c4: lcd_rst_n_o=%b, required 0", obs[0][c_b_rstn]);
            errors++;
        end
        tick();
        checks++;
        if (obs[0][c_b_rstn] !== 1'b1) begin
            $display("FAIL rst_high_c5: lcd_rst_n_o=%b, required 1", obs[0][c_b_rstn]);
            errors++;
        end
        serve_write(0, 2, w);
        checks++;
        if (w != 10) begin
            $display("FAIL first_we_cycle: init_we at cycle %0d, required 15", w + 5);
            errors++;
        end
        tick();
        checks++;
        if (obs[0][c_b_fin] !== 1'b0) begin
            $display("FAIL finish_early: init_finish=%b, required 0", obs[0][c_b_fin]);
            errors++;
        end
        tick();
        checks++;
        if ({obs[0][c_b_fin], obs[0][c_b_work]} !== 2'b10) begin
            $display("FAIL finish_rise: finish/work=%b/%b, required 1/0", obs[0][c_b_fin], obs[0][c_b_work]);
            errors++;
        end
        repeat (5) tick();
        checks++;
        if (obs[0][c_b_fin] !== 1'b1) begin
            $display("FAIL finish_sticky: init_finish=%b, required 1", obs[0][c_b_fin]);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int w;
        do_release();
        exp_q.push_back(wr_t'{1'b0, 16'h0036});
        exp_q.push_back(wr_t'{1'b1, 16'h0048});
        serve_write(1, 0, w);
        checks++;
        if (w != 15) begin
            $display("FAIL b2b_first: init_we at cycle %0d, required 15", w);
            errors++;
        end
        serve_write(1, 7, w);
        checks++;
        if (w != 2) begin
            $display("FAIL b2b_spacing: spacing %0d cycles, required 3", w + 1);
            errors++;
        end
        repeat (2) tick();
        checks++;
        if (obs[1][c_b_fin] !== 1'b1) begin
            $display("FAIL b2b_finish: init_finish=%b, required 1", obs[1][c_b_fin]);
            errors++;
        end
    endtask

    task automatic test_delay();
        int w;
        do_release();
        exp_q.push_back(wr_t'{1'b0, 16'h0029});
        serve_write(2, 0, w);
        checks++;
        if (w != 47) begin
            $display("FAIL delay_len: write at cycle %0d, required 47 (30 delay cycles)", w);
            errors++;
        end
    endtask

    task automatic test_zero_delay();
        int w;
        do_release();
        exp_q.push_back(wr_t'{1'b0, 16'h0029});
        serve_write(3, 0, w);
        checks++;
        if (w != 17) begin
            $display("FAIL zero_delay: write at cycle %0d, required 17", w);
            errors++;
        end
    endtask

    task automatic test_spurious_ack();
        int w;
        do_release();
        exp_q.push_back(wr_t'{1'b0, 16'h0029});
        for (int t = 1; t <= 46; t++) begin
            ack[2] = (t >= 6 && t <= 44);
            tick();
            checks++;
            if (obs[2][c_b_we] !== 1'b0 || obs[2][c_b_work] !== 1'b1) begin
                $display("FAIL spurious_ack c%0d: we/work=%b/%b, required 0/1", t, obs[2][c_b_we], obs[2][c_b_work]);
                errors++;
            end
        end
        ack[2] = 1'b0;
        serve_write(2, 0, w);
        checks++;
        if (w != 1) begin
            $display("FAIL spurious_exit: write at cycle %0d, required 47", w + 46);
            errors++;
        end
    endtask

    task automatic test_rst_mid();
        int w;
        do_release();
        repeat (20) tick();
        checks++;
        if ({obs[0][c_b_we], obs[2][c_b_work], obs[2][c_b_we]} !== 3'b110) begin
            $display("FAIL mid_setup: dut0 we=%b dut2 work/we=%b/%b, required 1 and 1/0",
                     obs[0][c_b_we], obs[2][c_b_work], obs[2][c_b_we]);
            errors++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs[0] !== 22'd0) begin
            $display("FAIL rst_mid_write: outputs=%h, required 000000", obs[0]);
            errors++;
        end
        checks++;
        if (obs[2] !== 22'd0) begin
            $display("FAIL rst_mid_delay: outputs=%h, required 000000", obs[2]);
            errors++;
        end
        rst = 1'b0;
        exp_q.push_back(wr_t'{1'b0, 16'h0011});
        tick();
        checks++;
        if ({obs[0][c_b_work], obs[0][c_b_rstn], obs[0][c_b_we]} !== 3'b100) begin
            $display("FAIL rst_restart: work/rst_n/we=%b/%b/%b, required 1/0/0",
                     obs[0][c_b_work], obs[0][c_b_rstn], obs[0][c_b_we]);
            errors++;
        end
        serve_write(0, 0, w);
        checks++;
        if (w != 14) begin
            $display("FAIL rst_rerun: write at cycle %0d, required 15", w + 1);
            errors++;
        end
    endtask

    task automatic test_no_end();
        int w;
        do_release();
        exp_q.push_back(wr_t'{1'b0, 16'h0011});
        exp_q.push_back(wr_t'{1'b0, 16'h0029});
        serve_write(4, 0, w);
        serve_write(4, 1, w);
        checks++;
        if ({obs[4][c_b_fin], obs[4][c_b_work]} !== 2'b10) begin
            $display("FAIL implicit_end: finish/work=%b/%b, required 1/0", obs[4][c_b_fin], obs[4][c_b_work]);
            errors++;
        end
        restart[4] = 1'b1;
        tick();
        restart[4] = 1'b0;
        checks++;
        if ({obs[4][c_b_fin], obs[4][c_b_work], obs[4][c_b_rstn]} !== 3'b010) begin
            $display("FAIL restart: finish/work/rst_n=%b/%b/%b, required 0/1/0",
                     obs[4][c_b_fin], obs[4][c_b_work], obs[4][c_b_rstn]);
            errors++;
        end
        exp_q.push_back(wr_t'{1'b0, 16'h0011});
        exp_q.push_back(wr_t'{1'b0, 16'h0029});
        for (int t = 2; t <= 14; t++) begin
            tick();
            checks++;
            if (obs[4][c_b_fin] !== 1'b0) begin
                $display("FAIL restart_finish c%0d: init_finish=%b, required 0", t, obs[4][c_b_fin]);
                errors++;
            end
        end
        serve_write(4, 0, w);
        checks++;
        if (w != 1) begin
            $display("FAIL restart_first: write at cycle %0d, required 15", w + 14);
            errors++;
        end
        serve_write(4, 0, w);
        checks++;
        if (obs[4][c_b_fin] !== 1'b1) begin
            $display("FAIL restart_done: init_finish=%b, required 1", obs[4][c_b_fin]);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_back_to_back();
        test_delay();
        test_zero_delay();
        test_spurious_ack();
        test_rst_mid();
        test_no_end();
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
            errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
